// File: rtl/rstgen_pkg.sv
// Shared definitions for the sequenced reset generator: FSM state encoding,
// parameter defaults and legal limits, and the stagger/hold counter sizing.
package rstgen_pkg;

  // Parameter defaults
  localparam int unsigned SYNC_STAGES_DEF = 4;
  localparam int unsigned NUM_CH_DEF      = 2;
  localparam int unsigned STAGGER_DEF     = 8;
  localparam int unsigned HOLD_CYC_DEF    = 16;

  // Legal parameter limits
  localparam int unsigned SYNC_STAGES_MIN = 2;
  localparam int unsigned SYNC_STAGES_MAX = 8;
  localparam int unsigned NUM_CH_MIN      = 1;
  localparam int unsigned NUM_CH_MAX      = 8;
  localparam int unsigned HOLD_CYC_MIN    = 1;
  localparam int unsigned HOLD_CYC_MAX    = 255;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_SYNC     = 2'd0,
    ST_RELEASE  = 2'd1,
    ST_DONE     = 2'd2,
    ST_SW_HOLD  = 2'd3
  } rstgen_state_e;

  // Width of the shared stagger/hold counter: enough to hold max(stagger, hold).
  function automatic int unsigned cnt_width(input int unsigned stagger,
                                            input int unsigned hold);
    int unsigned m;
    m = (stagger > hold) ? stagger : hold;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/rstgen_sync.sv
// Reset synchroniser: a shift chain of STAGES flops cleared asynchronously by
// rst_ni and filled with ones synchronously, so the output rises on the
// STAGES-th clock edge after rst_ni deasserts.
module rstgen_sync
  import rstgen_pkg::*;
#(
  parameter int unsigned STAGES = SYNC_STAGES_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic sync_o
);

  logic [STAGES-1:0] sync_q;

  // Shift ones in from stage 0; async clear on reset assertion.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], 1'b1};
    end
  end

  assign sync_o = sync_q[STAGES-1];

endmodule

// File: rtl/rstgen_seq.sv
// Sequenced reset generator. After rst_ni is synchronised, channel resets are
// released one after another, STAGGER cycles apart, and rst_done_o follows one
// cycle after the last channel. A DFT bypass routes rst_ni straight to the
// outputs when test_mode_i is set.
// Optional feature: define RSTGEN_SEQ_SW_RST_EN to add software-triggered
// resets (SW_HOLD state, HOLD_CYC-cycle assertion, one-cycle acknowledge).
module rstgen_seq
  import rstgen_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned NUM_CH      = NUM_CH_DEF,
  parameter int unsigned STAGGER     = STAGGER_DEF,
  parameter int unsigned HOLD_CYC    = HOLD_CYC_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              test_mode_i,
  input  logic              sw_rst_req_i,
  output logic [NUM_CH-1:0] rst_no,
  output logic [NUM_CH-1:0] init_no,
  output logic              rst_done_o,
  output logic              sw_rst_ack_o
);

  localparam int unsigned CW = cnt_width(STAGGER, HOLD_CYC);
  // Counter value on which the next channel is released (unused when STAGGER=0).
  localparam logic [CW-1:0] STAG_LAST = CW'((STAGGER > 0) ? (STAGGER - 1) : 0);
  // Release pattern applied on the first RELEASE edge: channel 0 only, or all
  // channels together when there is no stagger.
  localparam logic [NUM_CH-1:0] FIRST_REL =
    (STAGGER == 0) ? {NUM_CH{1'b1}} : NUM_CH'(1);

  rstgen_state_e     state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NUM_CH-1:0] rst_q, rst_d;
  logic              sync_rst;

`ifdef RSTGEN_SEQ_SW_RST_EN
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
  logic ack_q, ack_d;
`else
  logic unused_sw_rst_req;
  assign unused_sw_rst_req = sw_rst_req_i;
`endif

  rstgen_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .sync_o (sync_rst)
  );

  // Next-state logic: synchronise, stagger the releases, then idle in DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rst_d   = rst_q;
`ifdef RSTGEN_SEQ_SW_RST_EN
    ack_d   = 1'b0;
`endif
    case (state_q)
      ST_SYNC: begin
        if (sync_rst) begin
          state_d = ST_RELEASE;
          rst_d   = FIRST_REL;
          cnt_d   = '0;
        end
      end
      ST_RELEASE: begin
        if (&rst_q) begin
          // Last channel went out on the previous edge; done follows one cycle later.
          state_d = ST_DONE;
          cnt_d   = '0;
        end else if (cnt_q == STAG_LAST) begin
          rst_d = (rst_q << 1) | NUM_CH'(1);
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
`ifdef RSTGEN_SEQ_SW_RST_EN
        if (sw_rst_req_i) begin
          state_d = ST_SW_HOLD;
          rst_d   = '0;
          cnt_d   = '0;
          ack_d   = 1'b1;
        end
`endif
      end
`ifdef RSTGEN_SEQ_SW_RST_EN
      ST_SW_HOLD: begin
        // Already synchronous, so go straight back to releasing channels.
        if (cnt_q == HOLD_LAST) begin
          state_d = ST_RELEASE;
          rst_d   = FIRST_REL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`endif
      default: begin
        state_d = ST_SYNC;
        rst_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers; reset assertion aborts any sequence in progress.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_SYNC;
      cnt_q   <= '0;
      rst_q   <= '0;
`ifdef RSTGEN_SEQ_SW_RST_EN
      ack_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rst_q   <= rst_d;
`ifdef RSTGEN_SEQ_SW_RST_EN
      ack_q   <= ack_d;
`endif
    end
  end

  // Test mode bypasses the sequencer entirely with zero latency.
  assign rst_no     = test_mode_i ? {NUM_CH{rst_ni}} : rst_q;
  assign init_no    = test_mode_i ? {NUM_CH{1'b1}}   : rst_q;
  assign rst_done_o = test_mode_i ? rst_ni : (state_q == ST_DONE);

`ifdef RSTGEN_SEQ_SW_RST_EN
  assign sw_rst_ack_o = ack_q;
`else
  assign sw_rst_ack_o = 1'b0;
`endif

endmodule
